// File: rtl/fir_tx_pkg.sv
// Shared constants for the filter transmit path: FSM encodings, default sizes,
// and width helpers.
package fir_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    // Counter/pointer width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_DIV_W = clog2_min1(DEF_CLK_DIV);
    localparam int DEF_BIT_W = clog2_min1(DEF_DATA_W);
    localparam int DEF_PTR_W = clog2_min1(DEF_FIFO_DEPTH);
    localparam int DEF_CNT_W = $clog2(DEF_FIFO_DEPTH + 1);

endpackage

// File: rtl/fir_dac_serializer_if.sv
// Parallel sample valid/ready handshake between the filter pipeline and the
// DAC serializer.
interface fir_dac_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/fir_dac_serializer_sample_fifo.sv
// Synchronous sample FIFO with push/pop, full/empty and occupancy count.
// Full and empty decode from the registered count; overflow/underflow are gated.
module sample_fifo
    import fir_tx_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W     = clog2_min1(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fir_dac_serializer.sv
// Filter output serializer: buffers parallel samples and shifts each one
// MSB-first onto a 3-wire DAC interface (sclk, sdata, sync_n).
module fir_dac_serializer
    import fir_tx_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_dac_serializer_if.slave  s_in,
    output logic                 sclk,
    output logic                 sdata,
    output logic                 sync_n,
    output logic                 busy
);

    localparam int DIV_W = clog2_min1(CLK_DIV);
    localparam int BIT_W = clog2_min1(DATA_W);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_sr;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_sclk;
    logic              r_sdata;
    logic              r_sync_n;
    logic              r_busy;

    logic [1:0]        w_state_d;
    logic [DATA_W-1:0] w_sr_d;
    logic [DIV_W-1:0]  w_div_d;
    logic [BIT_W-1:0]  w_bit_cnt_d;
    logic              w_sclk_d;
    logic              w_sdata_d;
    logic              w_sync_n_d;
    logic              w_busy_d;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_fifo_data;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W-1:0]  w_count_d;
    logic              w_div_wrap;

    assign s_in.in_ready = !w_full;
    assign w_push        = s_in.in_valid && !w_full;
    assign w_div_wrap    = (r_div == DIV_W'(CLK_DIV - 1));

    sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (s_in.in_valid),
        .i_data  (s_in.in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_state_d   = r_state;
        w_sr_d      = r_sr;
        w_div_d     = r_div;
        w_bit_cnt_d = r_bit_cnt;
        w_sclk_d    = r_sclk;
        w_sdata_d   = r_sdata;
        w_sync_n_d  = r_sync_n;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_sr_d    = w_fifo_data;
                    w_state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_sync_n_d  = 1'b0;
                w_sdata_d   = r_sr[DATA_W-1];
                w_sclk_d    = 1'b0;
                w_div_d     = '0;
                w_bit_cnt_d = '0;
                w_state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_div_wrap) begin
                    w_div_d  = '0;
                    w_sclk_d = !r_sclk;
                    // Falling toggle: either advance to the next bit or close the frame.
                    if (r_sclk) begin
                        if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                            w_sync_n_d  = 1'b1;
                            w_sdata_d   = 1'b0;
                            w_bit_cnt_d = '0;
                            w_state_d   = ST_GAP;
                        end else begin
                            w_bit_cnt_d = r_bit_cnt + BIT_W'(1);
                            w_sr_d      = {r_sr[DATA_W-2:0], 1'b0};
                            w_sdata_d   = r_sr[DATA_W-2];
                        end
                    end
                end else begin
                    w_div_d = r_div + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (w_div_wrap) begin
                    w_div_d = '0;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_sr_d    = w_fifo_data;
                        w_state_d = ST_LOAD;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end else begin
                    w_div_d = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // busy is registered, so it is derived from next-cycle state and occupancy.
    always_comb begin
        w_count_d = w_fifo_count;
        if (w_push && !w_pop) begin
            w_count_d = w_fifo_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = w_fifo_count - CNT_W'(1);
        end
        w_busy_d = (w_state_d != ST_IDLE) || (w_count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sr      <= '0;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
            r_sync_n  <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_sr      <= w_sr_d;
            r_div     <= w_div_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_sclk    <= w_sclk_d;
            r_sdata   <= w_sdata_d;
            r_sync_n  <= w_sync_n_d;
            r_busy    <= w_busy_d;
        end
    end

    assign sclk   = r_sclk;
    assign sdata  = r_sdata;
    assign sync_n = r_sync_n;
    assign busy   = r_busy;

endmodule

// File: tb/tb_fir_dac_serializer.sv
// Directed bench for fir_dac_serializer: instance A at defaults, instance B with
// CLK_DIV=1. A negedge monitor decodes frames; the main thread checks them.
module tb_fir_dac_serializer;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    fir_dac_serializer_if #(.DATA_W(8)) if_a ();
    fir_dac_serializer_if #(.DATA_W(8)) if_b ();

    logic sclk_a, sdata_a, sync_n_a, busy_a;
    logic sclk_b, sdata_b, sync_n_b, busy_b;

    fir_dac_serializer #(.DATA_W(8), .CLK_DIV(4), .FIFO_DEPTH(4)) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .s_in   (if_a.slave),
        .sclk   (sclk_a),
        .sdata  (sdata_a),
        .sync_n (sync_n_a),
        .busy   (busy_a)
    );

    fir_dac_serializer #(.DATA_W(8), .CLK_DIV(1), .FIFO_DEPTH(4)) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .s_in   (if_b.slave),
        .sclk   (sclk_b),
        .sdata  (sdata_b),
        .sync_n (sync_n_b),
        .busy   (busy_b)
    );

    logic [1:0] w_sc, w_sd, w_sn, w_bz, w_rdy;
    assign w_sc  = {sclk_b, sclk_a};
    assign w_sd  = {sdata_b, sdata_a};
    assign w_sn  = {sync_n_b, sync_n_a};
    assign w_bz  = {busy_b, busy_a};
    assign w_rdy = {if_b.in_ready, if_a.in_ready};

    // Completed-frame records per instance, written only by the monitor.
    logic [7:0] fr_data   [2][32];
    int         fr_len    [2][32];
    int         fr_fall   [2][32];
    int         fr_end    [2][32];
    int         fr_rises  [2][32];
    int         fr_nontog [2][32];
    int         nfr       [2];
    logic       in_fr     [2];
    logic [7:0] cur_bits  [2];
    int         cur_len   [2];
    int         cur_rises [2];
    int         cur_fall  [2];
    int         cur_nontog[2];
    logic       prev_sclk [2];
    logic       prev_busy [2];
    int         bad_rise  [2];
    int         busy_fall [2];
    int         rdy_low   [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic mon_step(input int k);
        if (rst) begin
            in_fr[k]     = 1'b0;
            cur_rises[k] = 0;
            prev_sclk[k] = 1'b0;
            prev_busy[k] = 1'b0;
            return;
        end
        if (!w_sn[k]) begin
            if (!in_fr[k]) begin
                in_fr[k]      = 1'b1;
                cur_bits[k]   = 8'h00;
                cur_len[k]    = 0;
                cur_rises[k]  = 0;
                cur_nontog[k] = 0;
                cur_fall[k]   = cyc;
            end else if (w_sc[k] == prev_sclk[k]) begin
                cur_nontog[k]++;
            end
            cur_len[k]++;
            if (w_sc[k] && !prev_sclk[k]) begin
                cur_rises[k]++;
                cur_bits[k] = {cur_bits[k][6:0], w_sd[k]};
            end
        end else begin
            if (in_fr[k]) begin
                if (nfr[k] < 32) begin
                    fr_data[k][nfr[k]]   = cur_bits[k];
                    fr_len[k][nfr[k]]    = cur_len[k];
                    fr_fall[k][nfr[k]]   = cur_fall[k];
                    fr_end[k][nfr[k]]    = cyc;
                    fr_rises[k][nfr[k]]  = cur_rises[k];
                    fr_nontog[k][nfr[k]] = cur_nontog[k];
                end
                nfr[k]++;
                in_fr[k] = 1'b0;
            end
            if (w_sc[k] && !prev_sclk[k]) begin
                bad_rise[k]++;
            end
        end
        prev_sclk[k] = w_sc[k];
        if (prev_busy[k] && !w_bz[k]) begin
            busy_fall[k] = cyc;
        end
        prev_busy[k] = w_bz[k];
        if (!w_rdy[k]) begin
            rdy_low[k]++;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            nfr[k] = 0; in_fr[k] = 1'b0; bad_rise[k] = 0; busy_fall[k] = 0;
            rdy_low[k] = 0; prev_sclk[k] = 1'b0; prev_busy[k] = 1'b0; cur_rises[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) mon_step(k);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [7:0] d);
        if (k == 0) begin
            if_a.in_valid = v;
            if_a.in_data  = d;
        end else begin
            if_b.in_valid = v;
            if_b.in_data  = d;
        end
    endtask

    // Called at a negedge; returns the cycle index of the accepting edge.
    task automatic push(input int k, input logic [7:0] d, output int hs);
        int guard;
        guard = 0;
        drive(k, 1'b1, d);
        while (!w_rdy[k] && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check_eq("push_ready", {31'd0, w_rdy[k]}, 32'd1);
        @(negedge clk);
        hs = cyc;
    endtask

    task automatic wait_frames(input int k, input int target);
        int guard;
        guard = 0;
        while (nfr[k] < target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check_eq("frame_count", nfr[k], target);
    endtask

    task automatic wait_idle(input int k);
        int guard;
        guard = 0;
        while (w_bz[k] && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check_eq("busy_low", {31'd0, w_bz[k]}, 32'd0);
    endtask

    int         base;
    int         hs;
    int         hs_burst [4];
    int         rdy_before;
    logic [7:0] burst [4];
    logic [7:0] bp    [7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        burst = '{8'h01, 8'h80, 8'hFF, 8'h00};
        bp    = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check_eq("rst_sclk", {31'd0, sclk_a}, 32'd0);
        check_eq("rst_sdata", {31'd0, sdata_a}, 32'd0);
        check_eq("rst_sync_n", {31'd0, sync_n_a}, 32'd1);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_in_ready", {31'd0, if_a.in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single sample 0xA5.
        base = nfr[0];
        push(0, 8'hA5, hs);
        drive(0, 1'b0, 8'h00);
        wait_frames(0, base + 1);
        check_eq("a5_data", {24'd0, fr_data[0][base]}, 32'h0000_00A5);
        check_eq("a5_len", fr_len[0][base], 32'd64);
        check_eq("a5_latency", fr_fall[0][base] - hs, 32'd2);
        check_eq("a5_rises", fr_rises[0][base], 32'd8);
        wait_idle(0);
        check_eq("a5_busy_drop", busy_fall[0] - fr_end[0][base], 32'd4);

        // Burst on consecutive cycles.
        base = nfr[0];
        for (int i = 0; i < 4; i++) push(0, burst[i], hs_burst[i]);
        drive(0, 1'b0, 8'h00);
        for (int i = 1; i < 4; i++) check_eq("burst_accept", hs_burst[i] - hs_burst[i-1], 32'd1);
        wait_frames(0, base + 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("burst_data", {24'd0, fr_data[0][base+i]}, {24'd0, burst[i]});
            check_eq("burst_len", fr_len[0][base+i], 32'd64);
        end
        for (int i = 1; i < 4; i++) begin
            check_eq("burst_period", fr_fall[0][base+i] - fr_fall[0][base+i-1], 32'd69);
            check_eq("burst_gap", fr_fall[0][base+i] - fr_end[0][base+i-1], 32'd5);
        end
        wait_idle(0);

        // Back-pressure with seven samples.
        base       = nfr[0];
        rdy_before = rdy_low[0];
        for (int i = 0; i < 7; i++) push(0, bp[i], hs);
        drive(0, 1'b0, 8'h00);
        check_eq("bp_ready_dropped", {31'd0, rdy_low[0] > rdy_before}, 32'd1);
        wait_frames(0, base + 7);
        for (int i = 0; i < 7; i++) begin
            check_eq("bp_data", {24'd0, fr_data[0][base+i]}, {24'd0, bp[i]});
        end
        wait_idle(0);

        // Reset mid-frame with a second sample queued.
        base = nfr[0];
        push(0, 8'h5A, hs);
        push(0, 8'h11, hs);
        drive(0, 1'b0, 8'h00);
        for (int g = 0; g < 500 && !(in_fr[0] && cur_rises[0] == 3); g++) @(negedge clk);
        check_eq("abort_third_rise", cur_rises[0], 32'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_sync_n", {31'd0, sync_n_a}, 32'd1);
        check_eq("abort_sclk", {31'd0, sclk_a}, 32'd0);
        check_eq("abort_busy", {31'd0, busy_a}, 32'd0);
        check_eq("abort_in_ready", {31'd0, if_a.in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("abort_no_frame", nfr[0], base);
        check_eq("abort_idle", {31'd0, busy_a}, 32'd0);
        push(0, 8'h3C, hs);
        drive(0, 1'b0, 8'h00);
        wait_frames(0, base + 1);
        check_eq("post_data", {24'd0, fr_data[0][base]}, 32'h0000_003C);
        check_eq("post_len", fr_len[0][base], 32'd64);
        check_eq("post_rises", fr_rises[0][base], 32'd8);
        wait_idle(0);
        check_eq("a_bad_rises", bad_rise[0], 32'd0);

        // CLK_DIV=1 instance.
        base = nfr[1];
        push(1, 8'hC3, hs);
        drive(1, 1'b0, 8'h00);
        wait_frames(1, base + 1);
        check_eq("div1_data", {24'd0, fr_data[1][base]}, 32'h0000_00C3);
        check_eq("div1_len", fr_len[1][base], 32'd16);
        check_eq("div1_rises", fr_rises[1][base], 32'd8);
        check_eq("div1_toggle", fr_nontog[1][base], 32'd0);
        check_eq("div1_latency", fr_fall[1][base] - hs, 32'd2);
        wait_idle(1);
        check_eq("b_bad_rises", bad_rise[1], 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
